// File: rtl/tlight_multi.sv
// Round-robin traffic-light controller for N_APPROACH approaches with demand-actuated
// skipping, GO extension while nobody else waits, and a night-time yellow flash mode.
module tlight_multi #(
  parameter int N_APPROACH = 4,
  parameter int T_READY    = 4,
  parameter int T_GO       = 16,
  parameter int T_STOP     = 1,
  parameter int T_ALL_RED  = 2,
  parameter int T_FLASH    = 8,
  parameter bit DEMAND_EN  = 1'b1,
  parameter int CW         = 8,
  localparam int AW        = (N_APPROACH > 1) ? $clog2(N_APPROACH) : 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    night,
  input  logic [N_APPROACH-1:0]   demand,
  output logic [3*N_APPROACH-1:0] lights,
  output logic [AW-1:0]           active,
  output logic [2:0]              phase
);

  localparam int unsigned N_U = N_APPROACH;
  localparam logic [2:0] L_RED = 3'b100;
  localparam logic [2:0] L_YEL = 3'b010;
  localparam logic [2:0] L_GRN = 3'b001;
  localparam logic [2:0] L_OFF = 3'b000;

  typedef enum logic [2:0] {
    PH_RESET     = 3'd0,
    PH_READY     = 3'd1,
    PH_GO        = 3'd2,
    PH_STOP      = 3'd3,
    PH_ALL_RED   = 3'd4,
    PH_FLASH_ON  = 3'd5,
    PH_FLASH_OFF = 3'd6
  } phase_e;

  phase_e                  phase_q, phase_d;
  logic [AW-1:0]           active_q, active_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [N_APPROACH-1:0]   pending_q, pending_d;
  logic [3*N_APPROACH-1:0] lights_q, lights_d;

  logic [N_APPROACH-1:0]   pend_eff;
  logic [N_APPROACH-1:0]   act_mask;
  logic [N_APPROACH-1:0]   wait_vec;
  logic                    cnt_zero;
  logic [AW-1:0]           nxt_idx;
  logic                    found;
  int unsigned             idx;

  // Next approach to serve: first waiting index after the active one, wrapping.
  always_comb begin
    pend_eff           = DEMAND_EN ? (pending_q | demand) : '1;
    act_mask           = '0;
    act_mask[active_q] = 1'b1;
    wait_vec           = pend_eff & ~act_mask;
    cnt_zero           = (cnt_q == '0);
    nxt_idx            = (active_q == AW'(N_APPROACH - 1)) ? '0 : active_q + AW'(1);
    found              = 1'b0;
    idx                = 0;
    for (int unsigned k = 1; k < N_U; k++) begin
      idx = (32'(active_q) + k) % N_U;
      if (!found && wait_vec[idx]) begin
        found   = 1'b1;
        nxt_idx = AW'(idx);
      end
    end
  end

  // The counter holds at zero once a GO runs past T_GO, so the extension
  // decision is simply re-made every cycle until a waiter or night appears.
  always_comb begin
    phase_d   = phase_q;
    active_d  = active_q;
    cnt_d     = cnt_zero ? cnt_q : cnt_q - CW'(1);
    pending_d = DEMAND_EN ? (pending_q | demand) : '0;
    case (phase_q)
      PH_RESET: begin
        if (night) begin
          phase_d = PH_FLASH_ON;
          cnt_d   = CW'(T_FLASH - 1);
        end else begin
          phase_d  = PH_READY;
          active_d = '0;
          cnt_d    = CW'(T_READY - 1);
        end
      end
      PH_READY: begin
        if (cnt_zero) begin
          phase_d   = PH_GO;
          cnt_d     = CW'(T_GO - 1);
          pending_d = pending_d & ~act_mask;
        end
      end
      PH_GO: begin
        if (cnt_zero && ((|wait_vec) || night)) begin
          phase_d = PH_STOP;
          cnt_d   = CW'(T_STOP - 1);
        end
      end
      PH_STOP: begin
        if (cnt_zero) begin
          if (night) begin
            phase_d = PH_FLASH_ON;
            cnt_d   = CW'(T_FLASH - 1);
          end else begin
            phase_d  = PH_READY;
            active_d = nxt_idx;
            cnt_d    = CW'(T_READY - 1);
          end
        end
      end
      PH_FLASH_ON, PH_FLASH_OFF: begin
        if (cnt_zero) begin
          if (night) begin
            phase_d = (phase_q == PH_FLASH_ON) ? PH_FLASH_OFF : PH_FLASH_ON;
            cnt_d   = CW'(T_FLASH - 1);
          end else begin
            phase_d = PH_ALL_RED;
            cnt_d   = CW'(T_ALL_RED - 1);
          end
        end
      end
      PH_ALL_RED: begin
        if (cnt_zero) begin
          phase_d  = PH_READY;
          active_d = '0;
          cnt_d    = CW'(T_READY - 1);
        end
      end
      default: begin
        phase_d  = PH_RESET;
        active_d = '0;
        cnt_d    = '0;
      end
    endcase
  end

  // Lights are decoded from the next phase/active so the register lines up with phase_q.
  always_comb begin
    lights_d = '0;
    for (int unsigned i = 0; i < N_U; i++) begin
      case (phase_d)
        PH_READY, PH_STOP: lights_d[3*i +: 3] = (AW'(i) == active_d) ? L_YEL : L_RED;
        PH_GO:             lights_d[3*i +: 3] = (AW'(i) == active_d) ? L_GRN : L_RED;
        PH_FLASH_ON:       lights_d[3*i +: 3] = L_YEL;
        PH_FLASH_OFF:      lights_d[3*i +: 3] = L_OFF;
        default:           lights_d[3*i +: 3] = L_RED;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      phase_q   <= PH_RESET;
      active_q  <= '0;
      cnt_q     <= '0;
      pending_q <= '0;
      lights_q  <= {N_APPROACH{L_RED}};
    end else begin
      phase_q   <= phase_d;
      active_q  <= active_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      lights_q  <= lights_d;
    end
  end

  assign lights = lights_q;
  assign active = active_q;
  assign phase  = phase_q;

endmodule

// File: tb/tb_tlight_multi.sv
// Bench for tlight_multi: one fixed-demand and one demand-actuated instance, checked
// every cycle against a phase/elapsed-time reference model plus directed anchors.
module tb_tlight_multi;

  localparam int N  = 4;
  localparam int TR = 4;
  localparam int TG = 16;
  localparam int TS = 1;
  localparam int TA = 2;
  localparam int TF = 8;

  localparam int P_RESET = 0, P_READY = 1, P_GO = 2, P_STOP = 3;
  localparam int P_ALL_RED = 4, P_FLASH_ON = 5, P_FLASH_OFF = 6;

  logic           clock = 1'b0;
  logic           reset;
  logic           night;
  logic [N-1:0]   dem0, dem1;
  logic [3*N-1:0] l0, l1;
  logic [1:0]     a0, a1;
  logic [2:0]     p0, p1;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int base;

  int           m_ph  [2];
  int           m_act [2];
  int           m_el  [2];
  logic [N-1:0] m_pend[2];
  int           g_len [2];

  always #5 clock = ~clock;

  tlight_multi #(.N_APPROACH(N), .T_READY(TR), .T_GO(TG), .T_STOP(TS), .T_ALL_RED(TA),
                 .T_FLASH(TF), .DEMAND_EN(1'b0), .CW(8)) u_dut0 (
    .clock(clock), .reset(reset), .night(night), .demand(dem0),
    .lights(l0), .active(a0), .phase(p0));

  tlight_multi #(.N_APPROACH(N), .T_READY(TR), .T_GO(TG), .T_STOP(TS), .T_ALL_RED(TA),
                 .T_FLASH(TF), .DEMAND_EN(1'b1), .CW(8)) u_dut1 (
    .clock(clock), .reset(reset), .night(night), .demand(dem1),
    .lights(l1), .active(a1), .phase(p1));

  function automatic int dur(int ph);
    case (ph)
      P_READY:     return TR;
      P_GO:        return TG;
      P_STOP:      return TS;
      P_ALL_RED:   return TA;
      P_FLASH_ON:  return TF;
      P_FLASH_OFF: return TF;
      default:     return 1;
    endcase
  endfunction

  function automatic logic [3*N-1:0] exp_lights(int ph, int act);
    logic [3*N-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) begin
      case (ph)
        P_FLASH_ON:      v[3*i +: 3] = 3'b010;
        P_FLASH_OFF:     v[3*i +: 3] = 3'b000;
        P_READY, P_STOP: v[3*i +: 3] = (i == act) ? 3'b010 : 3'b100;
        P_GO:            v[3*i +: 3] = (i == act) ? 3'b001 : 3'b100;
        default:         v[3*i +: 3] = 3'b100;
      endcase
    end
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_ph[k] = P_RESET; m_act[k] = 0; m_el[k] = 0; m_pend[k] = '0; g_len[k] = 0;
    end
  endtask

  // k=0 models the always-demanded instance, k=1 the demand-actuated one.
  task automatic model_step(input int k, input logic [N-1:0] d, input logic nt);
    logic [N-1:0] w;
    int  nph, nact;
    bit  ends;
    w    = (k == 0) ? '1 : (m_pend[k] | d);
    w[m_act[k]] = 1'b0;
    ends = (m_el[k] + 1 >= dur(m_ph[k]));
    nph  = m_ph[k];
    nact = m_act[k];
    if (k == 1) m_pend[k] = m_pend[k] | d;
    if (ends) begin
      case (m_ph[k])
        P_RESET:   if (nt) nph = P_FLASH_ON; else begin nph = P_READY; nact = 0; end
        P_READY:   begin nph = P_GO; m_pend[k][m_act[k]] = 1'b0; end
        P_GO:      if (w != '0 || nt) nph = P_STOP;
        P_STOP: begin
          if (nt) nph = P_FLASH_ON;
          else begin
            nph  = P_READY;
            nact = (m_act[k] + 1) % N;
            for (int j = N - 1; j >= 1; j--)
              if (w[(m_act[k] + j) % N]) nact = (m_act[k] + j) % N;
          end
        end
        P_FLASH_ON:  nph = nt ? P_FLASH_OFF : P_ALL_RED;
        P_FLASH_OFF: nph = nt ? P_FLASH_ON  : P_ALL_RED;
        P_ALL_RED:   begin nph = P_READY; nact = 0; end
        default:     nph = P_RESET;
      endcase
    end
    m_el[k]  = (nph != m_ph[k]) ? 0 : m_el[k] + 1;
    m_ph[k]  = nph;
    m_act[k] = nact;
  endtask

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s[%0d] cyc=%0d observed=%h expected=%h", tag, k, cyc, obs, exp);
    end
  endtask

  task automatic check_inst(input int k, input logic [3*N-1:0] l, input logic [1:0] a, input logic [2:0] p);
    int nonred;
    bit green, inv_ok;
    chk("lights", k, 32'(l), 32'(exp_lights(m_ph[k], m_act[k])));
    chk("active", k, 32'(a), 32'(m_act[k]));
    chk("phase",  k, 32'(p), 32'(m_ph[k]));
    nonred = 0;
    green  = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (l[3*i +: 3] != 3'b100) nonred++;
      if (l[3*i +: 3] == 3'b001) green = 1'b1;
    end
    inv_ok = (p == 3'd5 || p == 3'd6) ? 1'b1 : (nonred <= 1 && (!green || p == 3'd2));
    chk("invariant", k, 32'(inv_ok), 32'd1);
    if (green) g_len[k]++;
    else if (g_len[k] > 0) begin
      chk("green_len", k, 32'(g_len[k] >= TG), 32'd1);
      g_len[k] = 0;
    end
  endtask

  task automatic check_all();
    check_inst(0, l0, a0, p0);
    check_inst(1, l1, a1, p1);
  endtask

  task automatic tick();
    @(posedge clock);
    model_step(0, dem0, night);
    model_step(1, dem1, night);
    #1;
    cyc++;
    check_all();
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; night = 1'b0; dem0 = '0; dem1 = '0;
    model_reset();
    #12;
    check_all();
    chk("rst_lights", 0, 32'(l0), 32'({N{3'b100}}));
    chk("rst_phase",  1, 32'(p1), 32'd0);
    @(posedge clock); #1;
    reset = 1'b1;

    // Fixed round-robin on instance 0; demand skip and extension on instance 1.
    run_to(1);
    chk("ready0", 0, 32'(l0), 32'({3'b100, 3'b100, 3'b100, 3'b010}));
    run_to(5);
    chk("go0", 0, 32'(l0), 32'({3'b100, 3'b100, 3'b100, 3'b001}));
    run_to(10);
    dem1 = 4'b0100;
    tick();
    dem1 = '0;
    run_to(21);
    chk("stop0", 0, 32'(p0), 32'd3);
    run_to(22);
    chk("ready1_act", 0, 32'(a0), 32'd1);
    chk("skip_act",   1, 32'(a1), 32'd2);
    run_to(65);
    chk("extend", 1, 32'(l1), 32'({3'b100, 3'b001, 3'b100, 3'b100}));
    dem1 = 4'b1000;
    tick();
    dem1 = '0;
    chk("ext_stop", 1, 32'(p1), 32'd3);
    run_to(67);
    chk("ext_next", 1, 32'(a1), 32'd3);
    run_to(85);
    chk("full_cycle_ph",  0, 32'(p0), 32'd1);
    chk("full_cycle_act", 0, 32'(a0), 32'd0);

    // Night requested mid-GO(1) on instance 0.
    run_to(114);
    night = 1'b1;
    run_to(126);
    chk("night_stop", 0, 32'(p0), 32'd3);
    run_to(127);
    chk("flash_on",  0, 32'(l0), 32'({N{3'b010}}));
    run_to(135);
    chk("flash_off", 0, 32'(l0), 32'd0);
    run_to(140);
    night = 1'b0;
    run_to(143);
    chk("all_red", 0, 32'(l0), 32'({N{3'b100}}));
    run_to(145);
    chk("post_night", 0, 32'(l0), 32'({3'b100, 3'b100, 3'b100, 3'b010}));

    // Asynchronous reset pulse in the middle of GO(2).
    run_to(195);
    chk("pre_rst_act", 0, 32'(a0), 32'd2);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("async_rst", 0, 32'(l0), 32'({N{3'b100}}));
    #2;
    reset = 1'b1;
    base = cyc;
    run_to(base + 1);
    chk("restart_ready", 0, 32'(l0), 32'({3'b100, 3'b100, 3'b100, 3'b010}));
    run_to(base + 22);
    chk("restart_act", 0, 32'(a0), 32'd1);

    // Random demand and occasional night toggles.
    repeat (2000) begin
      dem0 = N'($urandom);
      for (int i = 0; i < N; i++) dem1[i] = ($urandom_range(7) == 0);
      if ($urandom_range(199) == 0) night = ~night;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
